// File: rtl/tpi_bus_sequencer_if.sv
// Signal bundle linking the two register requesters, the bus sequencer and the 6523 pins.
// The master modport is the sequencer's view; the slave modport is the requester and pin side.
interface tpi_bus_sequencer_if;
  logic       req0;
  logic       we0;
  logic [2:0] rs0;
  logic [7:0] wdata0;
  logic       ack0;
  logic       req1;
  logic       we1;
  logic [2:0] rs1;
  logic [7:0] wdata1;
  logic       ack1;
  logic [7:0] rdata;
  logic       busy;
  logic       tpi_cs_n;
  logic       tpi_write_n;
  logic [2:0] tpi_rs;
  logic [7:0] tpi_data_o;
  logic       tpi_data_oe;
  logic [7:0] tpi_data_i;

  modport master (
    input  req0, we0, rs0, wdata0, req1, we1, rs1, wdata1, tpi_data_i,
    output ack0, ack1, rdata, busy, tpi_cs_n, tpi_write_n, tpi_rs, tpi_data_o, tpi_data_oe
  );

  modport slave (
    output req0, we0, rs0, wdata0, req1, we1, rs1, wdata1, tpi_data_i,
    input  ack0, ack1, rdata, busy, tpi_cs_n, tpi_write_n, tpi_rs, tpi_data_o, tpi_data_oe
  );
endinterface

// File: rtl/tpi_bus_sequencer.sv
// Round-robin two-port master for the 6523 triport register bus.
// Generates setup/strobe/hold-timed _cs cycles; every output comes straight from a flop.
module tpi_bus_sequencer #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                clock,
  input  logic                reset,
  tpi_bus_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       prio_q;
  logic       grant_q;
  logic       we_q;
  logic [2:0] rs_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       ack0_q;
  logic       ack1_q;
  logic       busy_q;
  logic       cs_n_q;
  logic       write_n_q;
  logic       oe_q;

  logic       any_req_s;
  logic       grant_d;
  logic       we_d;
  logic [2:0] rs_d;
  logic [7:0] wdata_d;

  // Arbiter: prio_q names the requester that wins when both ask at once.
  always_comb begin
    any_req_s = bus.req0 | bus.req1;
    grant_d   = 1'b0;
    we_d      = bus.we0;
    rs_d      = bus.rs0;
    wdata_d   = bus.wdata0;
    if (bus.req0 && bus.req1) begin
      grant_d = prio_q;
    end else if (bus.req1) begin
      grant_d = 1'b1;
    end else begin
      grant_d = 1'b0;
    end
    if (grant_d) begin
      we_d    = bus.we1;
      rs_d    = bus.rs1;
      wdata_d = bus.wdata1;
    end else begin
      we_d    = bus.we0;
      rs_d    = bus.rs0;
      wdata_d = bus.wdata0;
    end
  end

  // Cycle sequencer with registered pin, ack and read-data outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      prio_q    <= 1'b0;
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      rs_q      <= 3'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      write_n_q <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cs_n_q <= 1'b1;
          if (any_req_s) begin
            state_q   <= SETUP;
            cnt_q     <= SETUP_LOAD;
            grant_q   <= grant_d;
            prio_q    <= ~grant_d;
            we_q      <= we_d;
            rs_q      <= rs_d;
            wdata_q   <= wdata_d;
            write_n_q <= ~we_d;
            oe_q      <= we_d;
            busy_q    <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= STROBE;
            cnt_q   <= STROBE_LOAD;
            cs_n_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LOAD;
            cs_n_q  <= 1'b1;
            // Reads sample the bus on the edge that closes the last strobe cycle.
            if (!we_q) begin
              rdata_q <= bus.tpi_data_i;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q   <= DONE;
            write_n_q <= 1'b1;
            oe_q      <= 1'b0;
            ack0_q    <= ~grant_q;
            ack1_q    <= grant_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          cs_n_q    <= 1'b1;
          write_n_q <= 1'b1;
          oe_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.tpi_cs_n    = cs_n_q;
  assign bus.tpi_write_n = write_n_q;
  assign bus.tpi_rs      = rs_q;
  assign bus.tpi_data_o  = wdata_q;
  assign bus.tpi_data_oe = oe_q;

endmodule

// File: tb/tb_tpi_bus_sequencer.sv
// Self-checking bench: default-timing instance driven from a vector table and a scoreboard,
// plus a second instance with S=3/T=5/H=2 for the timing sweep.
`timescale 1ns/1ps
module tb_tpi_bus_sequencer;

  localparam int LAT_A = 5;  // 1 + S + T + H at default timing

  typedef struct {
    logic       port;
    logic       we;
    logic [2:0] rs;
    logic [7:0] wdata;
    logic [7:0] data_i;
    logic [7:0] rdata;
  } vec_t;

  typedef struct {
    logic       port;
    logic       we;
    logic [2:0] rs;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         ack_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  sb_t  sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tpi_bus_sequencer_if bus_a ();
  tpi_bus_sequencer_if bus_b ();

  tpi_bus_sequencer dut_a (.clock(clk), .reset(rst), .bus(bus_a));

  tpi_bus_sequencer #(.SETUP_CYCLES(3), .STROBE_CYCLES(5), .HOLD_CYCLES(2)) dut_b (
    .clock(clk), .reset(rst), .bus(bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor state for dut_a
  int         cs_run = 0;
  int         wn_run = 0;
  int         stab_err = 0;
  int         oe_err = 0;
  logic       snap_valid = 1'b0;
  logic [2:0] snap_rs;
  logic       snap_wn;
  logic       snap_oe;
  logic [7:0] snap_do;
  logic       prev_cs_low = 1'b0;
  logic [2:0] prev_rs;
  logic       prev_wn;
  logic [7:0] prev_do;
  sb_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      cs_run      = 0;
      wn_run      = 0;
      snap_valid  = 1'b0;
      prev_cs_low = 1'b0;
    end else begin
      if (!bus_a.tpi_cs_n) begin
        if (prev_cs_low && (bus_a.tpi_rs !== prev_rs || bus_a.tpi_write_n !== prev_wn ||
                            bus_a.tpi_data_o !== prev_do)) stab_err++;
        if (!snap_valid) begin
          snap_rs    = bus_a.tpi_rs;
          snap_wn    = bus_a.tpi_write_n;
          snap_oe    = bus_a.tpi_data_oe;
          snap_do    = bus_a.tpi_data_o;
          snap_valid = 1'b1;
        end
        cs_run++;
      end
      if (!bus_a.tpi_write_n) wn_run++;
      if (bus_a.tpi_data_oe && bus_a.tpi_write_n) oe_err++;
      prev_cs_low = !bus_a.tpi_cs_n;
      prev_rs     = bus_a.tpi_rs;
      prev_wn     = bus_a.tpi_write_n;
      prev_do     = bus_a.tpi_data_o;
      if (bus_a.ack0 || bus_a.ack1) begin
        check("ack_onehot", 32'(bus_a.ack0 & bus_a.ack1), 32'd0);
        check("ack_expected", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("ack_port", 32'(bus_a.ack1), 32'(mon_e.port));
          check("ack_cycle", cyc, mon_e.ack_cyc);
          check("rdata", 32'(bus_a.rdata), 32'(mon_e.rdata));
          check("cs_low_len", cs_run, 32'd2);
          check("write_n_low_len", wn_run, mon_e.we ? 32'd4 : 32'd0);
          check("strobe_seen", 32'(snap_valid), 32'd1);
          check("strobe_rs", 32'(snap_rs), 32'(mon_e.rs));
          check("strobe_write_n", 32'(snap_wn), 32'(!mon_e.we));
          check("strobe_oe", 32'(snap_oe), 32'(mon_e.we));
          if (mon_e.we) check("strobe_data_o", 32'(snap_do), 32'(mon_e.wdata));
        end
        cs_run     = 0;
        wn_run     = 0;
        snap_valid = 1'b0;
      end
    end
  end

  task automatic wait_idle_a();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!bus_a.busy) break;
    end
    check("idle_wait", 32'(bus_a.busy), 32'd0);
  endtask

  task automatic wait_ack_a(input logic port);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (port ? bus_a.ack1 : bus_a.ack0) break;
    end
    check("ack_wait", 32'(port ? bus_a.ack1 : bus_a.ack0), 32'd1);
  endtask

  task automatic drive_a(input vec_t v);
    if (v.port) begin
      bus_a.we1 = v.we; bus_a.rs1 = v.rs; bus_a.wdata1 = v.wdata; bus_a.req1 = 1'b1;
    end else begin
      bus_a.we0 = v.we; bus_a.rs0 = v.rs; bus_a.wdata0 = v.wdata; bus_a.req0 = 1'b1;
    end
    bus_a.tpi_data_i = v.data_i;
    sbq.push_back('{v.port, v.we, v.rs, v.wdata, v.rdata, cyc + LAT_A});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   c;
    int   csl;
    int   ack_at;
    int   ack_cnt;
    int   sweep_bad;

    vecs[0] = '{1'b0, 1'b1, 3'd3, 8'hFF, 8'h3C, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 3'd0, 8'hEE, 8'hA5, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 3'd7, 8'h11, 8'h5A, 8'h5A};
    vecs[3] = '{1'b1, 1'b1, 3'd6, 8'h12, 8'hFF, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 3'd2, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 3'd5, 8'h81, 8'h42, 8'h00};

    bus_a.req0 = 1'b0; bus_a.we0 = 1'b0; bus_a.rs0 = 3'd0; bus_a.wdata0 = 8'd0;
    bus_a.req1 = 1'b0; bus_a.we1 = 1'b0; bus_a.rs1 = 3'd0; bus_a.wdata1 = 8'd0;
    bus_a.tpi_data_i = 8'd0;
    bus_b.req0 = 1'b0; bus_b.we0 = 1'b0; bus_b.rs0 = 3'd0; bus_b.wdata0 = 8'd0;
    bus_b.req1 = 1'b0; bus_b.we1 = 1'b0; bus_b.rs1 = 3'd0; bus_b.wdata1 = 8'd0;
    bus_b.tpi_data_i = 8'd0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(bus_a.tpi_cs_n), 32'd1);
    check("rst_write_n", 32'(bus_a.tpi_write_n), 32'd1);
    check("rst_rs", 32'(bus_a.tpi_rs), 32'd0);
    check("rst_data_o", 32'(bus_a.tpi_data_o), 32'd0);
    check("rst_oe", 32'(bus_a.tpi_data_oe), 32'd0);
    check("rst_ack", 32'({bus_a.ack1, bus_a.ack0}), 32'd0);
    check("rst_rdata", 32'(bus_a.rdata), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Single transactions from the table
    for (int i = 0; i < 6; i++) begin
      wait_idle_a();
      drive_a(vecs[i]);
      wait_ack_a(vecs[i].port);
      bus_a.req0 = 1'b0;
      bus_a.req1 = 1'b0;
    end

    // Timing sweep on the S=3/T=5/H=2 instance
    @(posedge clk); #1;
    c = cyc;
    csl = 0; ack_at = -1; ack_cnt = 0; sweep_bad = 0;
    bus_b.we0 = 1'b1; bus_b.rs0 = 3'd5; bus_b.wdata0 = 8'h77; bus_b.req0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!bus_b.tpi_cs_n) csl++;
      if (cyc <= c + 10 && (bus_b.tpi_rs !== 3'd5 || bus_b.tpi_write_n !== 1'b0 ||
                            bus_b.tpi_data_o !== 8'h77)) sweep_bad++;
      if (bus_b.tpi_data_oe && bus_b.tpi_write_n) sweep_bad++;
      if (bus_b.ack0) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = cyc;
        bus_b.req0 = 1'b0;
      end
    end
    check("sweep_cs_len", csl, 32'd5);
    check("sweep_ack_cycle", ack_at, c + 11);
    check("sweep_ack_count", ack_cnt, 32'd1);
    check("sweep_stable", sweep_bad, 32'd0);
    check("sweep_rdata", 32'(bus_b.rdata), 32'd0);
    check("sweep_idle", 32'(bus_b.busy), 32'd0);

    // Reset while strobing: port 0 write aborted, then priority must be back on port 0
    wait_idle_a();
    bus_a.we0 = 1'b1; bus_a.rs0 = 3'd6; bus_a.wdata0 = 8'h5C; bus_a.req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus_a.tpi_cs_n) break;
    end
    check("abort_in_strobe", 32'(bus_a.tpi_cs_n), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(bus_a.tpi_cs_n), 32'd1);
    check("abort_busy", 32'(bus_a.busy), 32'd0);
    check("abort_oe", 32'(bus_a.tpi_data_oe), 32'd0);
    check("abort_write_n", 32'(bus_a.tpi_write_n), 32'd1);
    bus_a.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    // Contention: both requesters held high, grants must alternate 0,1,0,1
    @(posedge clk); #1;
    c = cyc;
    bus_a.we0 = 1'b1; bus_a.rs0 = 3'd1; bus_a.wdata0 = 8'hAA;
    bus_a.we1 = 1'b0; bus_a.rs1 = 3'd4; bus_a.wdata1 = 8'h00;
    bus_a.tpi_data_i = 8'hC3;
    sbq.push_back('{1'b0, 1'b1, 3'd1, 8'hAA, 8'h00, c + 5});
    sbq.push_back('{1'b1, 1'b0, 3'd4, 8'h00, 8'hC3, c + 11});
    sbq.push_back('{1'b0, 1'b1, 3'd1, 8'hAA, 8'hC3, c + 17});
    sbq.push_back('{1'b1, 1'b0, 3'd4, 8'h00, 8'hC3, c + 23});
    bus_a.req0 = 1'b1;
    bus_a.req1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0) break;
    end
    bus_a.req0 = 1'b0;
    bus_a.req1 = 1'b0;
    check("contention_drained", sbq.size(), 32'd0);

    // Request dropped during SETUP still completes exactly once
    wait_idle_a();
    bus_a.we0 = 1'b0; bus_a.rs0 = 3'd2; bus_a.wdata0 = 8'h00;
    bus_a.tpi_data_i = 8'h99;
    sbq.push_back('{1'b0, 1'b0, 3'd2, 8'h00, 8'h99, cyc + LAT_A});
    bus_a.req0 = 1'b1;
    @(posedge clk); #1;
    bus_a.req0 = 1'b0;
    check("drop_busy", 32'(bus_a.busy), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("drop_drained", sbq.size(), 32'd0);
    check("drop_idle", 32'(bus_a.busy), 32'd0);
    check("drop_rdata", 32'(bus_a.rdata), 32'h99);

    check("cs_stability", stab_err, 32'd0);
    check("oe_vs_write_n", oe_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
